xoodyak_cmd_sequencer: RTL
==========================

// Module: xoodyak_cmd_sequencer
// PURPOSE
//  Programmable command/data sequencer feeding xoodyak_build. Holds a script of DEPTH
//  {opmode, input_data, hold, expected} entries written through a config port. On start,
//  replays entries 0..num_steps-1 into the core over a valid/ready handshake, keeping each
//  opmode stable for its hold count. Captures core textout and, optionally, checks it in-line.
//  Successor to the fixed counter-indexed opmode/data tables; serves as on-chip self-test and
//  scripted host front-end.
// PARAMETERS
//  DEPTH   64   script entries; power of 2, >=2
//  OP_W    6    opmode width
//  DATA_W  352  core input_data width
//  TEXT_W  192  core textout width
//  HOLD_W  4    hold-count width; hold 0 is treated as 1
// PORTS
//  eph1               in   1            clock, rising edge
//  reset              in   1            asynchronous, active-low (0 = reset)
//  cfg_we             in   1            script write strobe
//  cfg_addr           in   $clog2(DEPTH) script write address
//  cfg_op             in   OP_W         entry opmode
//  cfg_data           in   DATA_W       entry input_data
//  cfg_hold           in   HOLD_W       entry hold cycles after accept
//  cfg_chk            in   1            entry result-check enable (XSEQ_CHECK_EN)
//  cfg_exp            in   TEXT_W       entry expected textout (XSEQ_CHECK_EN)
//  start              in   1            begin replay (level sampled, acted on in IDLE only)
//  abort              in   1            terminate replay
//  num_steps          in   $clog2(DEPTH)+1  entries to replay, 0..DEPTH
//  core_opmode        out  OP_W         opmode to core
//  core_data          out  DATA_W       input_data to core
//  core_op_valid      out  1            current entry offered to core
//  core_op_ready      in   1            core accepts entry
//  core_textout       in   TEXT_W       core result
//  core_textout_valid in   1            core result valid (1-cycle pulse)
//  busy               out  1            replay in progress
//  done               out  1            1-cycle pulse, replay completed (not on abort)
//  step_idx           out  $clog2(DEPTH) index of entry being driven
//  text_out           out  TEXT_W       last captured core_textout
//  text_valid         out  1            1-cycle pulse, text_out updated
//  mismatch_cnt       out  8            saturating count of failed checks
//  fail               out  1            sticky: any check failed since last start
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; all outputs 0; script RAM not cleared.
//  - States: IDLE -> ISSUE -> HOLD -> (ISSUE | DONE) -> IDLE.
//    IDLE: core_opmode=0, core_data=0, valid=0. start=1 & num_steps>0 -> ISSUE at step 0,
//      clears mismatch_cnt and fail. start=1 & num_steps=0 -> DONE directly.
//    ISSUE: drive entry[step_idx], core_op_valid=1; accept on valid&ready -> HOLD with
//      hold counter = max(hold,1)-1. First valid is 1 cycle after start sampled.
//    HOLD: valid=0, opmode/data held stable; counter reaches 0 -> step_idx+1 and ISSUE,
//      or DONE if step_idx == num_steps-1 (num_steps latched at start).
//    DONE: done=1 for one cycle, busy=0, then IDLE; opmode/data return to 0.
//  - busy=1 in ISSUE and HOLD only.
//  - cfg_we honoured only in IDLE/DONE; ignored while busy. Write and start in the same
//    cycle: write lands first, replay sees new entry.
//  - num_steps=DEPTH: step_idx wraps to 0 only via DONE; no wrap mid-replay.
//  - core_textout_valid in any state: text_out <= core_textout, text_valid pulses next cycle.
//  - abort (highest priority, any non-IDLE state): next cycle IDLE, valid=0, no done pulse;
//    mismatch_cnt/fail retained. abort and start together in IDLE: stay IDLE.
//  - start while busy ignored.
// CONFIGURATION
//  - XSEQ_CHECK_EN defined: script stores cfg_chk/cfg_exp; a textout_valid pulse during
//    ISSUE/HOLD of an entry with chk=1 compares core_textout to exp; mismatch ->
//    mismatch_cnt+1 (saturates at 255), fail <= 1.
//  - Undefined: cfg_chk/cfg_exp ports present but ignored, no storage; mismatch_cnt=0, fail=0.
// TESTING
//  - Reset: reset=0 mid-HOLD -> all outputs 0 immediately; after release IDLE, script intact.
//  - Replay 3 entries op {0x00,0x01,0x02}, hold {4,4,4}, ready=1 -> each opmode stable
//    5 cycles; done pulses once; busy falls with done.
//  - Backpressure: ready=0 for 7 cycles on entry 1 -> valid held, opmode/data unchanged,
//    step_idx=1; accepted on 8th cycle.
//  - Edge: num_steps=0 -> done 1 cycle after start, no valid; hold=0 behaves as hold=1;
//    num_steps=64 -> entry 63 driven then DONE.
//  - Abort in HOLD of step 2 -> IDLE next cycle, no done; subsequent start restarts at step 0.
//  - XSEQ_CHECK_EN: exp=0x87a0..0e30 vs core 0xbb44..de1e with chk=1 -> mismatch_cnt=1,
//    fail=1; matching result leaves 0; 300 mismatches -> mismatch_cnt=255.

Source files
------------

// File: rtl/xoodyak_cmd_sequencer.sv
// Scripted command/data sequencer for xoodyak_build.
// Replays a script of {opmode, input_data, hold} entries into the core over a
// valid/ready handshake and captures the core's textout.
// Optional in-line result checking is enabled by defining XSEQ_CHECK_EN.
module xoodyak_cmd_sequencer #(
  parameter int DEPTH  = 64,
  parameter int OP_W   = 6,
  parameter int DATA_W = 352,
  parameter int TEXT_W = 192,
  parameter int HOLD_W = 4
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [OP_W-1:0]          cfg_op,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic [HOLD_W-1:0]        cfg_hold,
  input  logic                     cfg_chk,
  input  logic [TEXT_W-1:0]        cfg_exp,
  input  logic                     start,
  input  logic                     abort,
  input  logic [$clog2(DEPTH):0]   num_steps,
  output logic [OP_W-1:0]          core_opmode,
  output logic [DATA_W-1:0]        core_data,
  output logic                     core_op_valid,
  input  logic                     core_op_ready,
  input  logic [TEXT_W-1:0]        core_textout,
  input  logic                     core_textout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [TEXT_W-1:0]        text_out,
  output logic                     text_valid,
  output logic [7:0]               mismatch_cnt,
  output logic                     fail
);

  localparam int            AW    = $clog2(DEPTH);
  localparam logic [AW:0]   ONE_N = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [AW:0]       num_q, num_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [TEXT_W-1:0] text_q;
  logic              text_valid_q;

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem [DEPTH];

  logic cfg_open;
  logic active;
  logic last_step;
  logic start_ok;

  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign active    = (state_q == S_ISSUE) || (state_q == S_HOLD);
  assign last_step = ({1'b0, step_q} == (num_q - ONE_N));
  assign start_ok  = (state_q == S_IDLE) && start && !abort;

  // Script write port; writes are locked out while a replay is running.
  // NOTE: the script RAM deliberately has no reset, so it survives a reset and
  // maps onto plain memory; only control state is reset.
  always_ff @(posedge eph1) begin
    if (cfg_we && cfg_open) begin
      op_mem[cfg_addr]   <= cfg_op;
      data_mem[cfg_addr] <= cfg_data;
      hold_mem[cfg_addr] <= cfg_hold;
    end
  end

  // Replay control state register.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: issue an entry, hold it, advance or finish; abort wins.
  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          num_d   = num_steps;
          step_d  = '0;
          state_d = (num_steps == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_op_ready) begin
          state_d = S_HOLD;
          cnt_d   = (hold_mem[step_q] == '0) ? '0 : hold_mem[step_q] - HOLD_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (last_step) begin
            state_d = S_DONE;
            step_d  = '0;
          end else begin
            state_d = S_ISSUE;
            step_d  = step_q + AW'(1);
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      step_d  = '0;
    end
  end

  assign core_opmode   = active ? op_mem[step_q]   : '0;
  assign core_data     = active ? data_mem[step_q] : '0;
  assign core_op_valid = (state_q == S_ISSUE);
  assign busy          = active;
  assign done          = (state_q == S_DONE);
  assign step_idx      = step_q;

  // Capture every core result regardless of replay state.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // all registers see pre-edge values of each other.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      text_q       <= '0;
      text_valid_q <= 1'b0;
    end else begin
      text_valid_q <= core_textout_valid;
      if (core_textout_valid) text_q <= core_textout;
    end
  end

  assign text_out   = text_q;
  assign text_valid = text_valid_q;

`ifdef XSEQ_CHECK_EN
  logic              chk_mem [DEPTH];
  logic [TEXT_W-1:0] exp_mem [DEPTH];
  logic [7:0]        mis_q;
  logic              fail_q;

  // Expected-result storage, written alongside the rest of the entry.
  always_ff @(posedge eph1) begin
    if (cfg_we && cfg_open) begin
      chk_mem[cfg_addr] <= cfg_chk;
      exp_mem[cfg_addr] <= cfg_exp;
    end
  end

  // Compare results against the active entry; cleared at each accepted start.
  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      mis_q  <= '0;
      fail_q <= 1'b0;
    end else if (start_ok) begin
      mis_q  <= '0;
      fail_q <= 1'b0;
    end else if (active && core_textout_valid && chk_mem[step_q] &&
                 (core_textout != exp_mem[step_q])) begin
      if (mis_q != 8'hff) mis_q <= mis_q + 8'd1;
      fail_q <= 1'b1;
    end
  end

  assign mismatch_cnt = mis_q;
  assign fail         = fail_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{cfg_chk, cfg_exp};
  assign mismatch_cnt = '0;
  assign fail         = 1'b0;
`endif

endmodule
